// File: rtl/dcp_haze_removal.sv
// dcp_haze_removal: streaming dark-channel-prior dehazer (1x1 patch), ALE pass then TE/recovery pass per frame
module dcp_haze_removal #(
  parameter int IMG_PIXELS = 262144,
  parameter int OMEGA      = 243,
  parameter int T0         = 26
) (
  input  logic        ACLK,
  input  logic        ARESETn,
  input  logic        enable,
  input  logic [31:0] S_AXIS_TDATA,
  input  logic        S_AXIS_TVALID,
  input  logic        S_AXIS_TLAST,
  output logic        S_AXIS_TREADY,
  output logic [31:0] M_AXIS_TDATA,
  output logic        M_AXIS_TVALID,
  output logic        M_AXIS_TLAST,
  input  logic        M_AXIS_TREADY
);
  localparam int CW = $clog2(IMG_PIXELS + 1);
  typedef enum logic {PASS1, PASS2} pass_e;
  pass_e           pass_q, pass_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [7:0]      ad_q, ad_d;
  logic [23:0]     a_q, a_d;
  logic            v1_q, l1_q, e1_q, v2_q, l2_q, e2_q;
  logic [23:0]     p1_q, a1_q, p2_q, a2_q;
  logic [7:0]      d1_q, ad1_q;
  logic [8:0]      t2_q, t2_d;
  logic [31:0]     m_data_q, m_data_d;
  logic            m_valid_q, m_last_q;
  logic [7:0]      r_in, g_in, b_in, rg_in, d_in;
  logic            acc, last_beat;
  logic [15:0]     num2, quo2;
  logic signed [17:0] traw2;
  logic            unused;

  assign unused        = ^{S_AXIS_TLAST, S_AXIS_TDATA[31:24]};
  assign S_AXIS_TREADY = M_AXIS_TREADY & ARESETn;
  assign acc           = S_AXIS_TVALID & S_AXIS_TREADY;
  assign r_in          = S_AXIS_TDATA[23:16];
  assign g_in          = S_AXIS_TDATA[15:8];
  assign b_in          = S_AXIS_TDATA[7:0];
  assign rg_in         = r_in < g_in ? r_in : g_in;
  assign d_in          = rg_in < b_in ? rg_in : b_in;
  assign last_beat     = cnt_q == CW'(IMG_PIXELS - 1);
  assign M_AXIS_TDATA  = m_data_q;
  assign M_AXIS_TVALID = m_valid_q;
  assign M_AXIS_TLAST  = m_last_q;

  // J = A + trunc((I - A) * 256 / t), saturated to 0..255
  function automatic logic [7:0] recover(input logic [7:0] i, input logic [7:0] a, input logic [8:0] t);
    logic signed [17:0] num, q, j;
    num = ($signed({10'd0, i}) - $signed({10'd0, a})) * 18'sd256;
    q   = num / $signed({9'd0, t});
    j   = $signed({10'd0, a}) + q;
    return j < 0 ? 8'd0 : j > 255 ? 8'd255 : j[7:0];
  endfunction

  // pass sequencing and atmospheric-light tracking; only beats with enable high count
  always_comb begin
    pass_d = pass_q;
    cnt_d  = cnt_q;
    ad_d   = ad_q;
    a_d    = a_q;
    if (acc && enable) begin
      cnt_d  = last_beat ? '0 : cnt_q + 1'b1;
      pass_d = last_beat ? (pass_q == PASS1 ? PASS2 : PASS1) : pass_q;
      if (pass_q == PASS1 && d_in > ad_q) begin
        ad_d = d_in;
        a_d  = S_AXIS_TDATA[23:0];
      end
      if (pass_q == PASS2 && last_beat) begin
        ad_d = '0;
        a_d  = '0;
      end
    end
  end

  // stage 2: transmission from the dark channel and the Ad snapshot carried with the pixel
  always_comb begin
    num2  = 16'(OMEGA) * {8'd0, d1_q};
    quo2  = num2 / {8'd0, (ad1_q == 8'd0 ? 8'd1 : ad1_q)};
    traw2 = 18'sd256 - $signed({2'b00, quo2});
    t2_d  = ad1_q == 8'd0 ? 9'd256 : (traw2 < T0 ? 9'(T0) : traw2[8:0]);
  end

  // stage 3: per-channel recovery, or passthrough for beats taken with enable low
  always_comb begin
    m_data_d = e2_q ? {8'h00, recover(p2_q[23:16], a2_q[23:16], t2_q),
                              recover(p2_q[15:8],  a2_q[15:8],  t2_q),
                              recover(p2_q[7:0],   a2_q[7:0],   t2_q)}
                    : {8'h00, p2_q};
  end

  // estimates and all three stages advance together only while downstream is ready
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      pass_q    <= PASS1;
      cnt_q     <= '0;
      ad_q      <= '0;
      a_q       <= '0;
      v1_q      <= 1'b0;
      l1_q      <= 1'b0;
      e1_q      <= 1'b0;
      p1_q      <= '0;
      a1_q      <= '0;
      d1_q      <= '0;
      ad1_q     <= '0;
      v2_q      <= 1'b0;
      l2_q      <= 1'b0;
      e2_q      <= 1'b0;
      p2_q      <= '0;
      a2_q      <= '0;
      t2_q      <= '0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      m_last_q  <= 1'b0;
    end else if (M_AXIS_TREADY) begin
      pass_q    <= pass_d;
      cnt_q     <= cnt_d;
      ad_q      <= ad_d;
      a_q       <= a_d;
      v1_q      <= acc & (~enable | (pass_q == PASS2));
      l1_q      <= enable & (pass_q == PASS2) & last_beat;
      e1_q      <= enable;
      p1_q      <= S_AXIS_TDATA[23:0];
      a1_q      <= a_q;
      d1_q      <= d_in;
      ad1_q     <= ad_q;
      v2_q      <= v1_q;
      l2_q      <= l1_q;
      e2_q      <= e1_q;
      p2_q      <= p1_q;
      a2_q      <= a1_q;
      t2_q      <= t2_d;
      m_data_q  <= m_data_d;
      m_valid_q <= v2_q;
      m_last_q  <= v2_q & l2_q;
    end
  end
endmodule

// File: tb/tb_dcp_haze_removal.sv
// tb_dcp_haze_removal: randomized and directed checks of the DCP dehazer against a frame-level model
module tb_dcp_haze_removal;
  localparam int N = 4, OMEGA = 243, T0 = 26;
  logic        ACLK = 1'b0, ARESETn = 1'b0, enable = 1'b1;
  logic [31:0] S_AXIS_TDATA = '0;
  logic        S_AXIS_TVALID = 1'b0, S_AXIS_TLAST = 1'b0, S_AXIS_TREADY;
  logic [31:0] M_AXIS_TDATA;
  logic        M_AXIS_TVALID, M_AXIS_TLAST;
  logic        M_AXIS_TREADY = 1'b1;
  int          checks = 0, failures = 0, base = 0;
  bit          rnd = 1'b0;
  logic [32:0] obs[$];
  logic [31:0] frm[4];
  logic [32:0] lit[4] = '{33'h0_00000C14, 33'h0_00C8B4DC, 33'h0_00000B00, 33'h1_00001211};
  bit          mpass = 1'b0;
  int          mcnt = 0, mad = 0;
  logic [23:0] ma = '0;
  bit          ev[3];
  bit          el[3];
  logic [31:0] ed[3];

  dcp_haze_removal #(.IMG_PIXELS(N), .OMEGA(OMEGA), .T0(T0)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn), .enable(enable),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TLAST(S_AXIS_TLAST),
    .S_AXIS_TREADY(S_AXIS_TREADY), .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TVALID(M_AXIS_TVALID),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string nm, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int dark(input logic [23:0] px);
    int m;
    m = int'(px[23:16]);
    if (int'(px[15:8]) < m) m = int'(px[15:8]);
    if (int'(px[7:0]) < m) m = int'(px[7:0]);
    return m;
  endfunction

  function automatic logic [23:0] recover(input logic [23:0] px, input logic [23:0] a, input int ad);
    int t, i, ac, j;
    logic [23:0] r;
    if (ad == 0) t = 256;
    else begin
      t = 256 - (OMEGA * dark(px)) / ad;
      if (t < T0) t = T0;
    end
    for (int c = 0; c < 3; c++) begin
      i  = int'(px[8*c +: 8]);
      ac = int'(a[8*c +: 8]);
      j  = ac + ((i - ac) * 256) / t;
      r[8*c +: 8] = j < 0 ? 8'd0 : j > 255 ? 8'd255 : 8'(j);
    end
    return r;
  endfunction

  always @(posedge ACLK) begin
    bit nv, nl;
    logic [31:0] nd;
    if (!ARESETn) begin
      mpass = 1'b0; mcnt = 0; mad = 0; ma = '0;
      for (int k = 0; k < 3; k++) ev[k] = 1'b0;
    end else if (M_AXIS_TREADY) begin
      if (M_AXIS_TVALID) obs.push_back({M_AXIS_TLAST, M_AXIS_TDATA});
      nv = 1'b0; nl = 1'b0; nd = '0;
      if (S_AXIS_TVALID) begin
        if (!enable) begin
          nv = 1'b1;
          nd = {8'h00, S_AXIS_TDATA[23:0]};
        end else if (!mpass) begin
          if (dark(S_AXIS_TDATA[23:0]) > mad) begin
            mad = dark(S_AXIS_TDATA[23:0]);
            ma  = S_AXIS_TDATA[23:0];
          end
          mcnt++;
          if (mcnt == N) begin mpass = 1'b1; mcnt = 0; end
        end else begin
          nv = 1'b1;
          nd = {8'h00, recover(S_AXIS_TDATA[23:0], ma, mad)};
          mcnt++;
          nl = (mcnt == N);
          if (nl) begin mpass = 1'b0; mcnt = 0; mad = 0; ma = '0; end
        end
      end
      ev[2] = ev[1]; ed[2] = ed[1]; el[2] = el[1];
      ev[1] = ev[0]; ed[1] = ed[0]; el[1] = el[0];
      ev[0] = nv;    ed[0] = nd;    el[0] = nl;
    end
  end

  always @(negedge ACLK) begin
    chk("m_tvalid", M_AXIS_TVALID, ev[2]);
    if (ev[2]) begin
      chk("m_tdata", M_AXIS_TDATA, ed[2]);
      chk("m_tlast", M_AXIS_TLAST, el[2]);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge ACLK);
      S_AXIS_TVALID = 1'b0;
      if (rnd) M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic send(input logic [31:0] px);
    int n;
    n = 0;
    if (rnd && $urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    @(negedge ACLK);
    S_AXIS_TDATA  = px;
    S_AXIS_TVALID = 1'b1;
    if (rnd) M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
    @(posedge ACLK);
    while (!M_AXIS_TREADY) begin
      n++;
      if (n > 50) begin
        checks++; failures++;
        $display("FAIL accept_timeout: got %0d cycles expected <= 50", n);
        break;
      end
      @(negedge ACLK);
      if (rnd) M_AXIS_TREADY = ($urandom_range(0, 3) != 0);
      @(posedge ACLK);
    end
  endtask

  task automatic set_en(input logic v);
    @(negedge ACLK);
    S_AXIS_TVALID = 1'b0;
    enable = v;
  endtask

  task automatic reset_pulse();
    @(negedge ACLK);
    ARESETn = 1'b0;
    S_AXIS_TVALID = 1'b0;
    @(negedge ACLK);
    chk("rst_tvalid", M_AXIS_TVALID, 0);
    chk("rst_tdata", M_AXIS_TDATA, 0);
    chk("rst_tlast", M_AXIS_TLAST, 0);
    chk("rst_tready", S_AXIS_TREADY, 0);
    ARESETn = 1'b1;
  endtask

  task automatic send_frame(input bit stall);
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < N; i++) begin
        if (stall && p == 1 && i == 2) begin
          @(negedge ACLK);
          M_AXIS_TREADY = 1'b0;
          S_AXIS_TDATA  = frm[i];
          S_AXIS_TVALID = 1'b1;
          for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            chk("stall_s_tready", S_AXIS_TREADY, 0);
          end
          M_AXIS_TREADY = 1'b1;
          @(posedge ACLK);
        end else send(frm[i]);
      end
    idle(6);
  endtask

  task automatic check_lit(input int b);
    chk("lit_count", 33'(obs.size()), 33'(b + 4));
    if (obs.size() >= b + 4)
      for (int i = 0; i < 4; i++) chk("lit_out", obs[b+i], lit[i]);
  endtask

  initial begin
    repeat (3) @(negedge ACLK);
    chk("rst_tvalid", M_AXIS_TVALID, 0);
    chk("rst_tdata", M_AXIS_TDATA, 0);
    chk("rst_tlast", M_AXIS_TLAST, 0);
    chk("rst_tready", S_AXIS_TREADY, 0);
    ARESETn = 1'b1;
    chk("pin_t243", recover(24'h0A141E, 24'hC8B4DC, 180), 24'h000C14);
    chk("pin_t26", recover(24'hC8B4DC, 24'hC8B4DC, 180), 24'hC8B4DC);
    chk("pin_t121", recover(24'h646464, 24'hC8B4DC, 180), 24'h000B00);
    chk("pin_t189", recover(24'h323C46, 24'hC8B4DC, 180), 24'h001211);
    chk("pin_ad0", recover(24'h123456, 24'h000000, 0), 24'h123456);
    frm = '{32'h000A141E, 32'h00C8B4DC, 32'h00646464, 32'h00323C46};
    base = obs.size();
    send_frame(1'b0);
    check_lit(base);
    base = obs.size();
    set_en(1'b0);
    send(32'hFF123456);
    set_en(1'b1);
    idle(5);
    chk("bypass_count", 33'(obs.size()), 33'(base + 1));
    if (obs.size() > base) chk("bypass_out", obs[base], {1'b0, 32'h00123456});
    base = obs.size();
    send(32'h0); send(32'h0);
    set_en(1'b0);
    send(32'h00AB0102);
    set_en(1'b1);
    send(32'h0); send(32'h0);
    for (int i = 0; i < N; i++) send(32'h0);
    idle(6);
    chk("black_count", 33'(obs.size()), 33'(base + 5));
    if (obs.size() >= base + 5) begin
      chk("black_bypass", obs[base], {1'b0, 32'h00AB0102});
      chk("black_last", obs[base+4], {1'b1, 32'h0});
    end
    for (int i = 0; i < N; i++) send(frm[i]);
    idle(1);
    chk("model_ad", 33'(mad), 33'd180);
    chk("model_a", {9'd0, ma}, 33'h00C8B4DC);
    send(frm[0]); send(frm[1]);
    reset_pulse();
    base = obs.size();
    send_frame(1'b0);
    check_lit(base);
    base = obs.size();
    send_frame(1'b1);
    check_lit(base);
    rnd = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < N; i++) frm[i] = $urandom;
      for (int p = 0; p < 2; p++)
        for (int i = 0; i < N; i++) begin
          if ($urandom_range(0, 7) == 0) begin
            set_en(1'b0);
            send($urandom);
            set_en(1'b1);
          end
          if (f == 3 && p == 1 && i == 1) reset_pulse();
          send(frm[i]);
        end
    end
    rnd = 1'b0;
    @(negedge ACLK);
    M_AXIS_TREADY = 1'b1;
    idle(8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dcp_haze_removal.md
Name: dcp_haze_removal

Overview:
- Streaming single-image haze remover using the Dark Channel Prior (DCP), with a 1x1 patch (per-pixel dark channel).
- Sits between an AXI4-Stream video source and sink.
- Each frame is sent twice:
  - Pass 1, Atmospheric Light Estimation (ALE): consumes pixels and produces no output.
  - Pass 2, Transmission Estimation (TE) and Scene Recovery (SRSC): emits one recovered pixel per input pixel.

Parameters:
- IMG_PIXELS, 262144, pixels per pass (512x512); sets the pass boundaries.
- OMEGA, 243, haze-retention factor in Q8 (about 0.95).
- T0, 26, minimum transmission in Q8 (about 0.1).

Ports:
- ACLK  in  1  clock.
- ARESETn  in  1  reset, synchronous, active-low.
- enable  in  1  1 = haze removal; 0 = passthrough.
- S_AXIS_TDATA  in  32  input pixel: [23:16] R, [15:8] G, [7:0] B; [31:24] ignored.
- S_AXIS_TVALID  in  1  input beat valid.
- S_AXIS_TLAST  in  1  ignored; passes are delimited by pixel count.
- S_AXIS_TREADY  out  1  input ready.
- M_AXIS_TDATA  out  32  output pixel, same packing; [31:24] always 0.
- M_AXIS_TVALID  out  1  output beat valid.
- M_AXIS_TLAST  out  1  high on the final pixel of pass 2.
- M_AXIS_TREADY  in  1  downstream ready.

Behaviour:
- Reset values (ARESETn low at a rising ACLK edge):
  - All outputs 0.
  - pass = PASS1, pixel counter 0, Ad = 0, A_R = A_G = A_B = 0, pipeline valids cleared.
- Handshakes:
  - S_AXIS_TREADY = M_AXIS_TREADY; the whole pipeline stalls when it is low.
  - A beat is accepted when TVALID and TREADY are both high.
- Dark channel: d = min(R, G, B), unsigned 8-bit.
- PASS1 (enable = 1):
  - On each accepted beat, if d > Ad (strict), load Ad = d and load (A_R, A_G, A_B) from that pixel.
  - Ties keep the earlier pixel.
  - M_AXIS_TVALID stays 0 throughout.
  - After IMG_PIXELS accepted beats, go to PASS2 and clear the counter.
- PASS2 (enable = 1), per accepted beat:
  - If Ad = 0: t = 256.
  - Otherwise: t = 256 - floor(OMEGA*d / Ad), then clamp t to at least T0.
  - For each channel c: J_c = A_c + trunc(((I_c - A_c)*256) / t).
    - Signed arithmetic, at least 18 bits.
    - Division truncates toward zero.
    - Saturate J_c to the range 0..255.
  - Output {8'h00, J_R, J_G, J_B}.
  - After IMG_PIXELS accepted beats, return to PASS1.
  - On entering PASS1, clear Ad and A_R/A_G/A_B to 0.
- Latency: fixed 3 ACLK cycles from acceptance to M_AXIS_TVALID, measured with no stalls. The stages are:
  - Stage 1: register pixel and d.
  - Stage 2: t.
  - Stage 3: J, saturation and output register.
- Throughput: one pixel per clock, continuous.
- Dividers may be combinational or internally pipelined, provided total latency stays 3.
- Bubbles (TVALID low mid-pass) are allowed; the counter advances only on accepted beats.
- M_AXIS_TLAST is high on the output beat produced by the IMG_PIXELS-th accepted beat of PASS2.
- enable = 0:
  - Output is the input with [31:24] zeroed, after the same 3-cycle latency.
  - The pass counter, Ad and the A registers hold their values.
  - M_AXIS_TLAST = 0.
- Changing enable mid-pass takes effect on the next accepted beat.
- Reset mid-operation discards in-flight pixels and returns to PASS1 with cleared estimates.
- No state advances while a beat is stalled.

Test Plan:
- Use IMG_PIXELS = 4, M_AXIS_TREADY = 1 throughout, unless stated otherwise.
- ALE pass: send 0x0A141E, 0xC8B4DC, 0x646464, 0x323C46 -> no M_AXIS_TVALID; Ad = 180; A = (200, 180, 220).
- Pass 2, same four pixels (a second 0xC8B4DC is permitted as a repeat) -> outputs 3 cycles after each input:
  - 0x0A141E: t = 243, output 0x00000C14.
  - 0xC8B4DC: t clamped to 26, output 0x00C8B4DC.
  - 0x646464: t = 121, output 0x00000B00.
  - TLAST high on the 4th output only.
- All-black frame for both passes -> Ad = 0, t = 256; pass-2 outputs equal the inputs (0x00000000).
- enable = 0, send 0xFF123456 -> output 0x00123456 after 3 cycles; TLAST = 0; counter unchanged.
- Drop M_AXIS_TREADY for 5 cycles mid-pass-2 -> S_AXIS_TREADY low for those cycles; no beats lost or duplicated; results bit-identical to the unstalled run.
- Assert ARESETn low for 1 cycle mid-pass-2 -> all outputs 0; next frame starts at PASS1.
